// File: rtl/square_wave_gen.sv
// square_wave_gen: programmable square-wave generator with double-buffered
// period / high-time / burst configuration. Changes made while running are
// parked in a shadow set and only become active at a period boundary, so the
// output never glitches mid-period.
module square_wave_gen #(
    parameter int CNT_W        = 32,
    parameter int BURST_W      = 16,
    parameter int SYS_CLK_FREQ = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    output logic               wave_out,
    output logic               period_tick,
    output logic               busy,
    output logic               done
);

    // Elaboration-time sanity check of the parameter set.
    if (CNT_W < 2 || BURST_W < 1 || SYS_CLK_FREQ < 1) begin : g_param_check
        $error("square_wave_gen: invalid parameter set");
    end

    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_TWO    = {{(CNT_W-2){1'b0}}, 2'b10};
    localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_MAX  = {BURST_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [BURST_W-1:0] nper, nper_next;
    logic [CNT_W-1:0]   per_a, per_a_next, high_a, high_a_next;
    logic [BURST_W-1:0] burst_a, burst_a_next;
    logic [CNT_W-1:0]   per_s, per_s_next, high_s, high_s_next;
    logic [BURST_W-1:0] burst_s, burst_s_next;
    logic               pend, pend_next;
    logic               stop_lat, stop_next;
    logic               finish;
    logic               wave_next, tick_next, busy_next, done_next, err_next;

    logic cfg_xfer;
    logic cfg_bad;
    logic cfg_ok;
    logic at_boundary;
    logic burst_end;
    logic stop_now;

    assign cfg_ready   = !pend;
    assign cfg_xfer    = cfg_valid && !pend;
    assign cfg_bad     = (cfg_period < CNT_TWO);
    assign cfg_ok      = cfg_xfer && !cfg_bad;
    // Compare against per_a - 1 before incrementing, so a full-scale period never overflows cnt.
    assign at_boundary = (cnt == (per_a - CNT_ONE));
    assign burst_end   = (burst_a != BURST_ZERO) && (nper == (burst_a - BURST_ONE));
    // A stop arriving in the last cycle of a period still ends that period.
    assign stop_now    = stop_lat || stop;

    // Next-state and datapath update: config routing, period counting, boundary actions.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        nper_next    = nper;
        per_a_next   = per_a;
        high_a_next  = high_a;
        burst_a_next = burst_a;
        per_s_next   = per_s;
        high_s_next  = high_s;
        burst_s_next = burst_s;
        pend_next    = pend;
        stop_next    = stop_lat;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_ok) begin
                    per_a_next   = cfg_period;
                    high_a_next  = cfg_high;
                    burst_a_next = cfg_burst;
                end else begin
                    per_a_next   = per_a;
                end
                if (start) begin
                    state_next = RUN;
                    cnt_next   = CNT_ZERO;
                    nper_next  = BURST_ZERO;
                    stop_next  = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (at_boundary) begin
                    cnt_next  = CNT_ZERO;
                    stop_next = 1'b0;
                    if (pend) begin
                        // New config starts a fresh burst count from this boundary.
                        per_a_next   = per_s;
                        high_a_next  = high_s;
                        burst_a_next = burst_s;
                        pend_next    = 1'b0;
                        nper_next    = BURST_ZERO;
                        finish       = stop_now;
                    end else begin
                        finish    = stop_now || burst_end;
                        nper_next = (nper == BURST_MAX) ? nper : (nper + BURST_ONE);
                    end
                    if (finish) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    cnt_next  = cnt + CNT_ONE;
                    stop_next = stop_now;
                end
                // pend is clear whenever a transfer can happen, so this never collides with the copy above.
                if (cfg_ok) begin
                    per_s_next   = cfg_period;
                    high_s_next  = cfg_high;
                    burst_s_next = cfg_burst;
                    pend_next    = 1'b1;
                end else begin
                    per_s_next   = per_s;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the next-state values, so the registered outputs line up with cnt.
    always_comb begin
        wave_next = 1'b0;
        tick_next = 1'b0;
        busy_next = (state_next == RUN);
        if (state_next == RUN) begin
            wave_next = (cnt_next < high_a_next);
            tick_next = (cnt_next == CNT_ZERO);
        end else begin
            wave_next = 1'b0;
            tick_next = 1'b0;
        end
        done_next = (state == RUN) && (state_next == IDLE);
        err_next  = cfg_xfer && cfg_bad;
    end

    // State, configuration and counter registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            cnt      <= CNT_ZERO;
            nper     <= BURST_ZERO;
            per_a    <= CNT_TWO;
            high_a   <= CNT_ONE;
            burst_a  <= BURST_ZERO;
            per_s    <= CNT_TWO;
            high_s   <= CNT_ONE;
            burst_s  <= BURST_ZERO;
            pend     <= 1'b0;
            stop_lat <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            nper     <= nper_next;
            per_a    <= per_a_next;
            high_a   <= high_a_next;
            burst_a  <= burst_a_next;
            per_s    <= per_s_next;
            high_s   <= high_s_next;
            burst_s  <= burst_s_next;
            pend     <= pend_next;
            stop_lat <= stop_next;
        end
    end

    // Registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wave_out    <= 1'b0;
            period_tick <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            wave_out    <= wave_next;
            period_tick <= tick_next;
            busy        <= busy_next;
            done        <= done_next;
            cfg_err     <= err_next;
        end
    end

endmodule

// File: doc/square_wave_gen.md
# square_wave_gen

Programmable square-wave generator producing a digital test signal of configurable period, high time and burst length. It runs entirely in the `sys_clk` domain and drives the signal consumed by the square-wave frequency and duty-cycle measurement path. Its main use is self-test and calibration of that path. Configuration is double-buffered, so period and duty changes only take effect at a period boundary and the output never glitches.

## Interface
- `CNT_W`, 32, width of the period and high-time counters and config fields.
- `BURST_W`, 16, width of the burst-length field.
- `SYS_CLK_FREQ`, 50_000_000, informational only; output frequency = SYS_CLK_FREQ / cfg_period.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous reset, active-high.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config can be accepted; a transfer occurs when `cfg_valid & cfg_ready`.
- `cfg_period`  in  CNT_W  period in sys_clk cycles; valid range is ≥ 2.
- `cfg_high`  in  CNT_W  high time in cycles.
- `cfg_burst`  in  BURST_W  number of periods to emit; 0 means continuous.
- `cfg_err`  out  1  one-cycle pulse when a config is rejected.
- `start`  in  1  begin generation (IDLE only).
- `stop`  in  1  graceful stop request (RUN only).
- `wave_out`  out  1  generated square wave, registered.
- `period_tick`  out  1  one-cycle pulse on the first cycle of each period, aligned with the rising edge of `wave_out`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- **States:** IDLE and RUN.
- **Active registers:** `per_a`, `high_a`, `burst_a`.
- **Shadow registers:** `per_s`, `high_s`, `burst_s`, plus a `pend` flag.
- **`cfg_ready`** = `!pend`.
- **Config transfer:**
  - If `cfg_period < 2`, the config is rejected. `cfg_err` pulses the next cycle and no register changes.
  - Otherwise, in IDLE, the values are written directly to the active registers.
  - Otherwise, in RUN, the values are written to the shadow registers and `pend` is set to 1.
- **Duty handling:**
  - `cfg_high = 0` gives a constant-low output (`period_tick` still pulses).
  - `cfg_high ≥ cfg_period` gives a constant-high output.
  - No clamping is stored; the comparison handles both cases.
- **Period counter `cnt`:**
  - Counts 0 to `per_a - 1` while in RUN.
  - At `cnt == per_a - 1` (the boundary), `cnt` wraps to 0 and `nper` (completed periods) increments.
- **Output:** `wave_out` is registered as `RUN && (cnt_next < high_a)`, so it is aligned with `cnt`.
- **Boundary actions, in priority order:**
  1. If `pend` is set, copy shadow to active, clear `pend`, and reset `nper` to 0.
  2. If a stop is latched, or `burst_a != 0` and `nper + 1 == burst_a`, go to IDLE.
  3. Otherwise, start the next period using the (possibly updated) active values.
- **`stop`** is latched in RUN and acted on at the next boundary. It is ignored in IDLE.
- **`start`** in IDLE goes to RUN with `cnt = 0` and `nper = 0`. It is ignored in RUN.
- **Simultaneous events:**
  - `start` and `stop` in IDLE: start wins.
  - `cfg` and `start` in IDLE in the same cycle: the new config is used for the first period.
  - `cfg` and a boundary in RUN in the same cycle: the config goes to shadow and applies at the following boundary.
- **Pending config at a stopping boundary:** it is still applied, and is retained for the next start.
- **`nper` width:** BURST_W; it saturates and is unused in continuous mode.

## Timing
- **Reset values:**
  - `wave_out`, `period_tick`, `busy`, `done`, `cfg_err` = 0.
  - `cfg_ready` = 1.
  - `per_a` = 2, `high_a` = 1, `burst_a` = 0.
  - `pend` = 0 and state = IDLE.
- **Reset mid-run:** takes effect on the next edge, with no `done` pulse.
- **Start latency:** with `start` sampled at edge t, at t+1 `busy` = 1, `period_tick` = 1, and `wave_out` = 1 (if `high_a > 0`).
- **Output shape:** `wave_out` is high for `min(high_a, per_a)` cycles, then low for the remainder of `per_a`.
- **Burst length:** a burst of B at period P keeps `busy` high for exactly B·P cycles. `done` pulses on the first IDLE cycle, with `wave_out` = 0 in that cycle.
- **Stop latency:** a stop at cycle k finishes the current period; `busy` falls at the boundary following k.
- **`cfg_err`:** 1 cycle after the rejected transfer.
- **`cfg_ready`:** falls 1 cycle after a RUN transfer and rises 1 cycle after the boundary that consumed the shadow.
- **Counter wrap:** `cnt` never exceeds `per_a - 1`. With `per_a` = 2^CNT_W − 1 there is no overflow, because the compare is done before the increment.

## Test plan
- **Fast 50 % wave:** reset; cfg P=2, H=1, B=0; start → `wave_out` toggles every cycle (25 MHz), `period_tick` every 2 cycles, `busy` stays 1.
- **Finite burst:** cfg P=10, H=3, B=4; start → 4 periods of 3 high / 7 low, `busy` high for 40 cycles, `done` on cycle 41, `wave_out` 0 afterwards.
- **Double-buffered update:** running P=8, H=4; mid-period cfg P=6, H=2 → current period completes as 8/4, next period is 6/2, no glitch; `cfg_ready` low from transfer+1 until the boundary+1.
- **Rejected and extreme duty:** cfg P=1 → `cfg_err` pulses and the config is unchanged. H=0 gives constant 0 with ticks. H=12 at P=10 gives constant 1.
- **Stop handling:** continuous run P=5; `stop` at `cnt`=1 → `busy` falls after `cnt`=4, `done` pulses. `start` and `stop` together in IDLE → generation starts.
- **Reset mid-run:** `sys_rst` asserted during a high phase → next cycle all outputs 0, `cfg_ready` = 1, no `done`; a subsequent start uses P=2, H=1.
